serial_transmitter_parity: RTL and testbench
============================================

Name: serial_transmitter_parity

Overview:
- Parity-framed serial transmitter: the upstream stage that drives the serial line consumed by the odd-parity serial receiver.
- Accepts a byte over a valid/ready handshake and serialises it as one frame: start bit 0, 8 data bits LSB first, odd parity bit, stop bit(s) 1.
- Line idles high. At the default CLKS_PER_BIT=1 it sends one bit per clock, matching the receiver's sampling rate.

Parameters:
- CLKS_PER_BIT, 1, clock cycles each line bit is held; legal range 1..65535.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  byte offered on i_byte.
- i_byte  input  8  byte to transmit.
- o_ready  output  1  block can accept a byte this cycle.
- o_data  output  1  serial line, registered, idles high.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, o_data=1, o_busy=0, o_done=0, o_ready=1.
  - Bit counter, clock-divider counter and shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - o_ready = (state==IDLE), decoded combinationally from the state register.
  - Transfer occurs on a rising edge where i_valid && o_ready.
  - On transfer, i_byte is latched into the shift register and the parity bit is computed as ~^i_byte (odd parity: total ones across data and parity is odd). State goes to START.
  - i_valid outside IDLE is ignored. No transfer occurs and no state changes.
  - Changes on i_byte after the transfer edge have no effect on the current frame.
- Line timing:
  - o_data is registered. The first start-bit cycle is the cycle after the transfer edge.
  - Each bit is held for exactly CLKS_PER_BIT cycles. A divider counter counts 0..CLKS_PER_BIT-1; the bit or state advances at terminal count.
- START: o_data=0, then go to DATA.
- DATA: o_data=shift[0]. Shift right at the end of each bit. A 3-bit index counts 0..7; go to PARITY after index 7.
- PARITY: o_data=latched parity bit, then go to STOP.
- STOP:
  - o_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - o_done=1 during the final cycle of the last stop bit, then return to IDLE.
- Frame length is (10+STOP_BITS)*CLKS_PER_BIT cycles.
- o_busy=1 in every state except IDLE.
- Back-to-back frames: after STOP, at least one IDLE cycle with o_data=1 precedes the next start bit. With i_valid held high, the next transfer happens in that IDLE cycle.
- Reset mid-frame:
  - Applies on the next edge: o_data=1, IDLE, o_done stays 0.
  - The partially sent byte is discarded and not resent.
- Reset and i_valid in the same cycle: reset wins and no transfer occurs.
- o_done never asserts outside STOP and never lasts more than one cycle.

Optional Feature:
- Macro: TX_PARITY_EVEN_EN.
- Defined: parity bit = ^i_byte (even parity). All other timing is unchanged.
- Undefined (default): odd parity, ~^i_byte, which matches the odd-parity receiver.

Test Plan:
- Reset, then idle 5 cycles -> o_data=1, o_ready=1, o_busy=0, o_done=0 throughout.
- Send 0x55, CLKS_PER_BIT=1, STOP_BITS=1 -> o_data sequence 0,1,0,1,0,1,0,1,0,1,1 on the 11 cycles after transfer. o_done high on the 11th cycle. Back in IDLE next cycle.
- Send 0xAA then 0x01 with i_valid held high, with the serial receiver connected:
  - 0xAA -> parity 1; 0x01 -> parity 0.
  - Exactly one idle-high cycle between frames.
  - Receiver reports out_byte 0xAA then 0x01, each with done=1.
- Send 0x00 and 0xFF -> parity bit 1 for both. With TX_PARITY_EVEN_EN defined -> parity 0 for both.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x3C -> each bit held 4 cycles. Frame is 48 cycles. o_done on cycle 48 only.
- Assert rst during data bit 3 of 0x55 -> o_data=1 on the next edge, IDLE, o_done never pulses. A new 0x55 sent afterwards is framed correctly.

Source files
------------

// File: rtl/serial_transmitter_parity.sv
// Purpose: parity-framed serial transmitter (start, 8 data LSB first, parity, stop bits).
// Latency: start bit on o_data the cycle after the accepting edge; frame = (10+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: o_ready is high only in IDLE; i_valid is ignored while a frame is in flight.
// Build option: define TX_PARITY_EVEN_EN to send even parity instead of the default odd parity.
module serial_transmitter_parity #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_data,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic        ONE_CLK   = (CLKS_PER_BIT == 1);
    localparam logic        ONE_STOP  = (STOP_BITS == 1);

    state_t      state;
    logic [15:0] div_cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  shift;
    logic        parity;
    logic        parity_calc;
    logic        div_term;

    // Parity is computed from the offered byte so it is latched together with the data.
`ifdef TX_PARITY_EVEN_EN
    assign parity_calc = ^i_byte;
`else
    assign parity_calc = ~^i_byte;
`endif

    assign div_term = (div_cnt == DIV_LAST);
    assign o_ready  = (state == IDLE);

    // Frame sequencer: every output is registered and loaded with the value of the next line cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            o_data   <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            parity   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= div_term ? 16'd0 : div_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift    <= i_byte;
                        parity   <= parity_calc;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        o_data   <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (div_term) begin
                        o_data <= shift[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (div_term) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            o_data <= parity;
                            state  <= PARITY;
                        end else begin
                            o_data  <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (div_term) begin
                        o_data   <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                        // Done is registered, so it is raised one cycle ahead of the final stop cycle.
                        o_done   <= ONE_CLK && ONE_STOP;
                    end
                end
                STOP: begin
                    if (div_term) begin
                        if (stop_idx == STOP_LAST) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            o_done   <= ONE_CLK;
                        end
                    end else begin
                        o_done <= (stop_idx == STOP_LAST) && ((div_cnt + 16'd1) == DIV_LAST);
                    end
                end
                default: begin
                    o_data <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter_parity.sv
// Bench for serial_transmitter_parity: one instance at 1 clk/bit + 1 stop, one at 4 clk/bit + 2 stops.
// Drivers push expected frames into per-instance queues; monitors rebuild each frame from the line.
// Build option: TX_PARITY_EVEN_EN flips the expected parity in the reference model.
module tb_serial_transmitter_parity;

    logic       clk = 1'b0;
    logic       rst   [2];
    logic       valid [2];
    logic [7:0] din   [2];
    logic       ready [2];
    logic       data  [2];
    logic       busy  [2];
    logic       done  [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_busy [2];

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_transmitter_parity #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .i_valid(valid[0]), .i_byte(din[0]),
        .o_ready(ready[0]), .o_data(data[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    serial_transmitter_parity #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .i_valid(valid[1]), .i_byte(din[1]),
        .o_ready(ready[1]), .o_data(data[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    function automatic int cpb_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Reference parity: total ones over data+parity is odd (or even with the build option).
    function automatic logic exp_par(input logic [7:0] b);
        int ones;
        ones = $countones(b);
`ifdef TX_PARITY_EVEN_EN
        return (ones % 2) == 1;
`else
        return (ones % 2) == 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e.b = '0;
        e.start = 0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Offer a byte and wait for acceptance; returns one step after the accepting edge.
    task automatic send(input int k, input logic [7:0] b, input bit hold);
        exp_t e;
        bit   got;
        got = 1'b0;
        valid[k] = 1'b1;
        din[k]   = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready[k] === 1'b1 && !rst[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("ready_timeout", {63'd0, ready[k]}, 64'd1);
            valid[k] = 1'b0;
        end else begin
            e.b     = b;
            e.start = cyc + 1;
            push_exp(k, e);
            @(posedge clk);
            #1;
            din[k] = 8'($urandom);
            if (!hold) valid[k] = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((qsize(k) != 0 || mon_busy[k]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(qsize(k)) + {63'd0, mon_busy[k]}, 64'd0);
        step(1);
    endtask

    // Monitor: reconstructs every frame from the line and compares it with the queued expectation.
    task automatic monitor(input int k);
        int         cpb;
        int         len;
        int         t;
        int         bad;
        int         bi;
        bit         in_frame;
        bit         gap;
        bit         ok;
        exp_t       e;
        logic [47:0] cap;
        logic [7:0] dec;
        logic [3:0] ev;
        logic       eb;
        cpb = cpb_of(k);
        len = (10 + sb_of(k)) * cpb;
        in_frame = 1'b0;
        gap = 1'b0;
        t = 0;
        bad = 0;
        cap = '1;
        forever begin
            @(negedge clk);
            if (!in_frame) begin
                if (data[k] === 1'b0 && !gap) begin
                    pop_exp(k, e, ok);
                    if (!ok) begin
                        chk("unexpected_start", {63'd0, data[k]}, 64'd1);
                    end else begin
                        chk("start_cycle", 64'(cyc), 64'(e.start));
                        in_frame = 1'b1;
                        mon_busy[k] = 1'b1;
                        t = 0;
                        bad = 0;
                    end
                end else begin
                    chk(gap ? "gap_after_frame" : "idle_line",
                        {60'd0, data[k], busy[k], ready[k], done[k]}, 64'b1010);
                    gap = 1'b0;
                end
            end
            if (in_frame) begin
                bi = t / cpb;
                eb = (bi == 0) ? 1'b0 : (bi <= 8) ? e.b[bi-1] : (bi == 9) ? exp_par(e.b) : 1'b1;
                ev = {eb, 1'b1, 1'b0, (t == len - 1)};
                cap[t] = data[k];
                if ({data[k], busy[k], ready[k], done[k]} !== ev) bad++;
                t++;
                if (rst[k]) begin
                    chk("aborted_frame_mismatches", 64'(bad), 64'd0);
                    in_frame = 1'b0;
                    gap = 1'b1;
                    mon_busy[k] = 1'b0;
                end else if (t == len) begin
                    for (int i = 0; i < 8; i++) dec[i] = cap[cpb * (1 + i) + cpb / 2];
                    chk("frame_cycle_mismatches", 64'(bad), 64'd0);
                    chk("decoded_byte", {56'd0, dec}, {56'd0, e.b});
                    chk("parity_bit", {63'd0, cap[9 * cpb + cpb / 2]}, {63'd0, exp_par(e.b)});
                    in_frame = 1'b0;
                    gap = 1'b1;
                    mon_busy[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic rand_traffic(input int k, input int n);
        logic [7:0] b;
        bit         hold;
        for (int i = 0; i < n; i++) begin
            b    = 8'($urandom);
            hold = ($urandom_range(0, 2) == 0);
            send(k, b, hold);
            if (!hold) step($urandom_range(0, 3));
        end
        valid[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            valid[k] = 1'b0;
            din[k] = 8'h00;
            mon_busy[k] = 1'b0;
        end
        step(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_idle_dut0", {60'd0, data[0], busy[0], ready[0], done[0]}, 64'b1010);
            chk("reset_idle_dut1", {60'd0, data[1], busy[1], ready[1], done[1]}, 64'b1010);
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        step(1);

        // Directed cases on the 1 clk/bit instance.
        send(0, 8'h55, 1'b0);
        wait_idle(0);
        send(0, 8'hAA, 1'b1);
        send(0, 8'h01, 1'b0);
        wait_idle(0);
        send(0, 8'h00, 1'b0);
        send(0, 8'hFF, 1'b0);
        wait_idle(0);
        // Reset during data bit 3 of 0x55.
        send(0, 8'h55, 1'b0);
        step(4);
        rst[0] = 1'b1;
        step(1);
        rst[0] = 1'b0;
        step(3);
        // Reset together with a valid offer: nothing may be accepted.
        rst[0] = 1'b1;
        valid[0] = 1'b1;
        din[0] = 8'h99;
        step(1);
        rst[0] = 1'b0;
        valid[0] = 1'b0;
        step(3);
        send(0, 8'h55, 1'b0);
        wait_idle(0);

        // Directed cases on the 4 clk/bit, 2 stop instance.
        send(1, 8'h3C, 1'b0);
        send(1, 8'h00, 1'b1);
        send(1, 8'hFF, 1'b0);
        wait_idle(1);

        fork
            rand_traffic(0, 40);
            rand_traffic(1, 15);
        join
        wait_idle(0);
        wait_idle(1);
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
